// File: rtl/muldiv_unit_if.sv
// rtl/muldiv_unit_if.sv - request/result bundle between the control FSM and muldiv_unit
//
// Purpose: groups the launch request and the result/status lines of the
// multiply/divide unit so the datapath and its controller share one port.
//
// Signals:
//   start  launch request for func (master -> slave)
//   func   MIPS funct field (master -> slave)
//   opa    rs operand: multiplicand / dividend / MTHI-MTLO data (master -> slave)
//   opb    rt operand: multiplier / divisor (master -> slave)
//   busy   operation in progress (slave -> master)
//   done   one-cycle pulse when HI/LO were written by mul/div (slave -> master)
//   div0   sticky divide-by-zero flag (slave -> master)
//   hi/lo  architectural HI/LO registers (slave -> master)
//   res    MFHI/MFLO read data (slave -> master)
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [5:0]       func;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             busy;
  logic             done;
  logic             div0;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] res;

  modport master (
    output start, func, opa, opb,
    input  busy, done, div0, hi, lo, res
  );

  modport slave (
    input  start, func, opa, opb,
    output busy, done, div0, hi, lo, res
  );
endinterface

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative MIPS MULT/MULTU/DIV/DIVU unit owning HI/LO
//
// Purpose: one-bit-per-clock radix-2 shift-add multiplier and restoring
// divider, with MFHI/MFLO read mux and MTHI/MTLO writes.
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  synchronous active-low reset
//   bus    muldiv_unit_if slave: start/func/opa/opb in;
//          busy/done/div0/hi/lo/res out
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input logic          clk,
  input logic          rst_n,
  muldiv_unit_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  // acc_hi/acc_lo: product (mul) or remainder/quotient (div) working register
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  // multiplicand (mul) or divisor (div) magnitude
  logic [WIDTH-1:0] operand_b;
  logic             op_div;
  logic             neg_q;
  logic             neg_r;
  logic             div0_q;
  logic             done_q;

  // launch decode
  logic             is_muldiv;
  logic             op_signed;
  logic             op_is_div;
  logic             b_zero;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             neg_q_in;
  logic             neg_r_in;

  always_comb begin
    is_muldiv = (bus.func == F_MULT) || (bus.func == F_MULTU) ||
                (bus.func == F_DIV)  || (bus.func == F_DIVU);
    op_signed = (bus.func == F_MULT) || (bus.func == F_DIV);
    op_is_div = (bus.func == F_DIV)  || (bus.func == F_DIVU);
    b_zero    = (bus.opb == '0);
    a_neg     = op_signed && bus.opa[WIDTH-1];
    b_neg     = op_signed && bus.opb[WIDTH-1];
    // Divide by zero keeps the raw dividend so the restoring loop leaves
    // hi = opa and lo = all ones, with no sign fix-up afterwards.
    a_mag     = (a_neg && !(op_is_div && b_zero)) ? -bus.opa : bus.opa;
    b_mag     = b_neg ? -bus.opb : bus.opb;
    neg_q_in  = (a_neg ^ b_neg) && !(op_is_div && b_zero);
    neg_r_in  = a_neg && op_is_div && !b_zero;
  end

  // one iteration of either algorithm
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_rem_sh;
  logic               div_ok;
  logic [WIDTH-1:0]   div_sub;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  always_comb begin
    mul_sum    = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand_b} : '0);
    div_rem_sh = {acc_hi, acc_lo[WIDTH-1]};
    div_ok     = (div_rem_sh >= {1'b0, operand_b});
    // When div_ok the difference is below the divisor, so the low bits suffice.
    div_sub    = div_rem_sh[WIDTH-1:0] - operand_b;
    prod_fix   = neg_q ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
    quo_fix    = neg_q ? -acc_lo : acc_lo;
    rem_fix    = neg_r ? -acc_hi : acc_hi;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.start && is_muldiv) state_nxt = CALC;
      CALC: if (cnt == CNT_W'(1)) state_nxt = FIX;
      FIX:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      acc_hi    <= '0;
      acc_lo    <= '0;
      operand_b <= '0;
      op_div    <= 1'b0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      div0_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (is_muldiv) begin
              acc_hi    <= '0;
              acc_lo    <= op_is_div ? a_mag : b_mag;
              operand_b <= op_is_div ? b_mag : a_mag;
              cnt       <= CNT_W'(WIDTH);
              op_div    <= op_is_div;
              neg_q     <= neg_q_in;
              neg_r     <= neg_r_in;
              div0_q    <= op_is_div && b_zero;
            end else if (bus.func == F_MTHI) begin
              hi_q <= bus.opa;
            end else if (bus.func == F_MTLO) begin
              lo_q <= bus.opa;
            end
          end
        end
        CALC: begin
          cnt <= cnt - CNT_W'(1);
          if (op_div) begin
            acc_hi <= div_ok ? div_sub : div_rem_sh[WIDTH-1:0];
            acc_lo <= {acc_lo[WIDTH-2:0], div_ok};
          end else begin
            {acc_hi, acc_lo} <= {mul_sum, acc_lo[WIDTH-1:1]};
          end
        end
        FIX: begin
          if (op_div) begin
            hi_q <= rem_fix;
            lo_q <= quo_fix;
          end else begin
            {hi_q, lo_q} <= prod_fix;
          end
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state != IDLE);
  assign bus.done = done_q;
  assign bus.div0 = div0_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

  always_comb begin
    bus.res = '0;
    if (bus.func == F_MFHI) begin
      bus.res = hi_q;
    end else if (bus.func == F_MFLO) begin
      bus.res = lo_q;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - randomized and directed bench for muldiv_unit against a behavioural model
module tb_muldiv_unit;

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  muldiv_unit_if #(.WIDTH(32)) bus32 ();
  muldiv_unit_if #(.WIDTH(8))  bus8 ();

  muldiv_unit #(.WIDTH(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));
  muldiv_unit #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Arithmetic result of a mul/div on w-bit operands, returned as {hi, lo}.
  function automatic logic [63:0] model_op(input int w, input logic [5:0] f,
                                           input logic [63:0] a, input logic [63:0] b);
    logic [63:0] mask;
    logic [63:0] ua;
    logic [63:0] ub;
    longint      sa;
    longint      sb;
    logic [63:0] p;
    logic [63:0] q;
    logic [63:0] r;
    mask = (64'h1 << w) - 64'h1;
    ua = a & mask;
    ub = b & mask;
    sa = $signed(ua << (64 - w)) >>> (64 - w);
    sb = $signed(ub << (64 - w)) >>> (64 - w);
    q = '0;
    r = '0;
    case (f)
      F_MULT: begin
        p = 64'(sa * sb);
        r = (p >> w) & mask;
        q = p & mask;
      end
      F_MULTU: begin
        p = ua * ub;
        r = (p >> w) & mask;
        q = p & mask;
      end
      F_DIV: begin
        if (ub == 0) begin
          q = mask;
          r = ua;
        end else begin
          q = 64'(sa / sb) & mask;
          r = 64'(sa % sb) & mask;
        end
      end
      F_DIVU: begin
        if (ub == 0) begin
          q = mask;
          r = ua;
        end else begin
          q = ua / ub;
          r = ua % ub;
        end
      end
      default: ;
    endcase
    return {r[31:0], q[31:0]};
  endfunction

  // Behavioural model of the 32-bit instance: result is scheduled WIDTH+1
  // edges after launch; while an op is pending every start is dropped.
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic        m_done = 1'b0;
  logic        m_div0 = 1'b0;
  int          m_left = 0;
  logic [63:0] m_res = '0;
  bit          model_on = 1'b0;

  always @(posedge clk) begin
    model_on = 1'b1;
    if (!rst_n) begin
      m_hi = '0;
      m_lo = '0;
      m_done = 1'b0;
      m_div0 = 1'b0;
      m_left = 0;
    end else begin
      m_done = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_hi = m_res[63:32];
          m_lo = m_res[31:0];
          m_done = 1'b1;
        end
      end else if (bus32.start) begin
        case (bus32.func)
          F_MULT, F_MULTU, F_DIV, F_DIVU: begin
            m_res = model_op(32, bus32.func, {32'h0, bus32.opa}, {32'h0, bus32.opb});
            m_left = 33;
            m_div0 = ((bus32.func == F_DIV) || (bus32.func == F_DIVU)) && (bus32.opb == 32'h0);
          end
          F_MTHI: m_hi = bus32.opa;
          F_MTLO: m_lo = bus32.opa;
          default: ;
        endcase
      end
    end
  end

  always @(posedge clk) begin
    logic [31:0] exp_res;
    #1;
    if (model_on) begin
      exp_res = (bus32.func == F_MFHI) ? m_hi : (bus32.func == F_MFLO) ? m_lo : 32'h0;
      check("busy", {63'h0, bus32.busy}, {63'h0, m_left > 0});
      check("done", {63'h0, bus32.done}, {63'h0, m_done});
      check("div0", {63'h0, bus32.div0}, {63'h0, m_div0});
      check("hi", {32'h0, bus32.hi}, {32'h0, m_hi});
      check("lo", {32'h0, bus32.lo}, {32'h0, m_lo});
      check("res", {32'h0, bus32.res}, {32'h0, exp_res});
    end
  end

  // Called at a negedge; start is sampled at the following posedge and the
  // task returns at the negedge right after that launch edge.
  task automatic launch32(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    bus32.start = 1'b1;
    bus32.func = f;
    bus32.opa = a;
    bus32.opb = b;
    @(negedge clk);
    bus32.start = 1'b0;
    bus32.func = 6'h3F;
    bus32.opa = $urandom;
    bus32.opb = $urandom;
  endtask

  // n = edges after the launch edge until done is seen.
  task automatic wait32(output int n);
    n = 0;
    while (!bus32.done && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", {63'h0, bus32.done}, 64'h1);
  endtask

  task automatic run8(input string name, input logic [5:0] f, input logic [7:0] a,
                      input logic [7:0] b, input logic [7:0] exp_hi, input logic [7:0] exp_lo);
    int n;
    logic [63:0] mr;
    bus8.start = 1'b1;
    bus8.func = f;
    bus8.opa = a;
    bus8.opb = b;
    @(negedge clk);
    bus8.start = 1'b0;
    bus8.opa = 8'($urandom);
    bus8.opb = 8'($urandom);
    n = 0;
    while (!bus8.done && n < 20) begin
      @(negedge clk);
      n++;
    end
    mr = model_op(8, f, {56'h0, a}, {56'h0, b});
    check({name, "_latency"}, 64'(n), 64'd9);
    check({name, "_hi"}, {56'h0, bus8.hi}, {56'h0, exp_hi});
    check({name, "_lo"}, {56'h0, bus8.lo}, {56'h0, exp_lo});
    check({name, "_model"}, {24'h0, bus8.hi, 24'h0, bus8.lo}, mr);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom % 8)
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      4: return 32'h7FFFFFFF;
      5: return $urandom % 16;
      default: return $urandom;
    endcase
  endfunction

  logic [5:0] ftab [10] = '{F_MULT, F_MULTU, F_DIV, F_DIVU, F_MFHI,
                            F_MFLO, F_MTHI, F_MTLO, 6'h00, 6'h3F};

  initial begin
    int n;
    int seen;
    bus32.start = 1'b0;
    bus32.func = 6'h3F;
    bus32.opa = '0;
    bus32.opb = '0;
    bus8.start = 1'b0;
    bus8.func = 6'h3F;
    bus8.opa = '0;
    bus8.opb = '0;

    repeat (3) @(negedge clk);
    check("rst_busy", {63'h0, bus32.busy}, 64'h0);
    check("rst_done", {63'h0, bus32.done}, 64'h0);
    check("rst_div0", {63'h0, bus32.div0}, 64'h0);
    check("rst_hi", {32'h0, bus32.hi}, 64'h0);
    check("rst_lo", {32'h0, bus32.lo}, 64'h0);
    rst_n = 1'b1;

    launch32(F_MULT, 32'hFFFFFFFE, 32'h3);
    wait32(n);
    check("mult_latency", 64'(n), 64'd33);
    check("mult_hi", {32'h0, bus32.hi}, 64'hFFFFFFFF);
    check("mult_lo", {32'h0, bus32.lo}, 64'hFFFFFFFA);

    launch32(F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait32(n);
    check("multu_hi", {32'h0, bus32.hi}, 64'hFFFFFFFE);
    check("multu_lo", {32'h0, bus32.lo}, 64'h1);

    launch32(F_DIV, 32'hFFFFFFF9, 32'h2);
    wait32(n);
    check("div_lo", {32'h0, bus32.lo}, 64'hFFFFFFFD);
    check("div_hi", {32'h0, bus32.hi}, 64'hFFFFFFFF);

    launch32(F_DIV, 32'h80000000, 32'hFFFFFFFF);
    wait32(n);
    check("divovf_lo", {32'h0, bus32.lo}, 64'h80000000);
    check("divovf_hi", {32'h0, bus32.hi}, 64'h0);
    check("divovf_div0", {63'h0, bus32.div0}, 64'h0);

    launch32(F_DIVU, 32'd100, 32'h0);
    wait32(n);
    check("div0_flag", {63'h0, bus32.div0}, 64'h1);
    check("div0_lo", {32'h0, bus32.lo}, 64'hFFFFFFFF);
    check("div0_hi", {32'h0, bus32.hi}, 64'd100);

    launch32(F_MULT, 32'd3, 32'd4);
    check("div0_cleared", {63'h0, bus32.div0}, 64'h0);
    repeat (5) @(negedge clk);
    bus32.start = 1'b1;
    bus32.func = F_DIVU;
    bus32.opa = 32'd9;
    bus32.opb = 32'd0;
    @(negedge clk);
    bus32.func = F_MTHI;
    bus32.opa = 32'h1234;
    @(negedge clk);
    bus32.start = 1'b0;
    bus32.func = 6'h3F;
    wait32(n);
    check("ignored_hi", {32'h0, bus32.hi}, 64'h0);
    check("ignored_lo", {32'h0, bus32.lo}, 64'd12);
    launch32(F_MULTU, 32'd5, 32'd6);
    check("done_single", {63'h0, bus32.done}, 64'h0);
    check("b2b_busy", {63'h0, bus32.busy}, 64'h1);
    wait32(n);
    check("b2b_lo", {32'h0, bus32.lo}, 64'd30);

    launch32(F_MULT, 32'h12345, 32'h777);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_busy", {63'h0, bus32.busy}, 64'h0);
    check("midrst_hi", {32'h0, bus32.hi}, 64'h0);
    check("midrst_lo", {32'h0, bus32.lo}, 64'h0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus32.done) seen++;
    end
    check("midrst_no_done", 64'(seen), 64'h0);

    bus32.start = 1'b1;
    bus32.func = F_MTLO;
    bus32.opa = 32'hABCD;
    @(negedge clk);
    bus32.start = 1'b0;
    bus32.func = F_MFLO;
    #1;
    check("mflo_res", {32'h0, bus32.res}, 64'hABCD);

    run8("mult8", F_MULT, 8'h7F, 8'h02, 8'h00, 8'hFE);
    run8("divovf8", F_DIV, 8'h80, 8'hFF, 8'h00, 8'h80);
    run8("div8", F_DIV, 8'hF9, 8'h02, 8'hFF, 8'hFD);
    run8("divu8_zero", F_DIVU, 8'h64, 8'h00, 8'h64, 8'hFF);

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      bus32.start = (($urandom % 4) == 0);
      bus32.func = ftab[$urandom % 10];
      bus32.opa = pick();
      bus32.opb = pick();
      rst_n = !(i == 1500);
    end
    @(negedge clk);
    bus32.start = 1'b0;
    rst_n = 1'b1;
    repeat (40) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
